// File: rtl/alu_arbiter.sv
// Two-requester front end to a single shared ALU: arbitrates, executes one operation,
// then holds the result until the consumer takes it.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter bit          RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic             prio_q;  // requester that wins when both are valid
  logic [3:0]       ctl_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;

  // Grant is recomputed every idle cycle from the current valids.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle && !reset) begin
      if (req0_valid && req1_valid) begin
        if (RR_EN && prio_q) gnt1 = 1'b1;
        else                 gnt0 = 1'b1;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state_q == StResp);

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (ctl_q)
      4'd0:    alu_res = a_q & b_q;
      4'd1:    alu_res = a_q | b_q;
      4'd2:    alu_res = a_q + b_q;
      4'd6:    alu_res = a_q - b_q;
      4'd7:    alu_res[0] = (a_q < b_q);
      4'd12:   alu_res = ~(a_q | b_q);
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      prio_q     <= 1'b0;
      ctl_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt0 || gnt1) begin
            ctl_q   <= gnt1 ? req1_ctl : req0_ctl;
            a_q     <= gnt1 ? req1_a : req0_a;
            b_q     <= gnt1 ? req1_b : req0_b;
            rsp_id  <= gnt1;
            prio_q  <= ~gnt1;
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_result <= alu_res;
          rsp_zero   <= (alu_res == '0);
          rsp_err    <= alu_err;
          state_q    <= StResp;
        end
        StResp: begin
          if (rsp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
